// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W_DEF = 32;
  localparam int X0_IDX    = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_sequencer_if.sv
// Hazard inputs from the pipeline stages and the control/perf outputs back to them.
interface hazard_sequencer_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [CNT_W-1:0] lu_events;

  // Pipeline side: reports hazard sources, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    input  pc_write, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_timeout, stall_cycles, flush_events, lu_events
  );

  // Sequencer side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_busy,
    output pc_write, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_timeout, stall_cycles, flush_events, lu_events
  );
endinterface

// File: rtl/hazard_mem_watchdog.sv
// Counts consecutive data-memory busy cycles; raises a sticky timeout flag
// once the count reaches MEM_TIMEOUT. The flag only clears on reset.
module hazard_mem_watchdog #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_busy,
  output logic mem_timeout
);
  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  logic [WD_W-1:0] wd_cnt_d, wd_cnt_q;
  logic            timeout_d, timeout_q;

  // Saturating busy counter; any idle cycle restarts the count.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (mem_busy) begin
      if (wd_cnt_q == WD_MAX) begin
        wd_cnt_d = WD_MAX;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_ONE;
      end
      if (wd_cnt_d == WD_MAX) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      wd_cnt_d  = '0;
      timeout_d = timeout_q;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;
endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, branch
// flushes, memory-wait freeze and a stuck-memory watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter outputs read zero.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hazard_sequencer_if.slave  hz
);
  hz_state_e state_d, state_q;
  logic lu_match_s, lu_allow_s, br_allow_s;
  logic pc_write_s, if_id_hold_s, if_id_flush_s, id_ex_bubble_s, pipe_freeze_s;
  logic mem_timeout_s;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu_match_s = hz.ex_mem_read && (hz.ex_rd != REG_W'(X0_IDX)) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Decide which hazard sources are live in the current state; the cycle
  // after a bubble must not detect the same hazard again.
  always_comb begin
    lu_allow_s = 1'b0;
    br_allow_s = 1'b0;
    case (state_q)
      RUN:      begin lu_allow_s = 1'b1; br_allow_s = 1'b1; end
      LU_STALL: begin lu_allow_s = 1'b0; br_allow_s = 1'b1; end
      FLUSH:    begin lu_allow_s = 1'b0; br_allow_s = 1'b0; end
      MEM_WAIT: begin lu_allow_s = 1'b1; br_allow_s = 1'b1; end
      default:  begin lu_allow_s = 1'b1; br_allow_s = 1'b1; end
    endcase
  end

  // Prioritised control decode and next-state; reset forces a flush pattern.
  always_comb begin
    pc_write_s     = 1'b1;
    if_id_hold_s   = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    pipe_freeze_s  = 1'b0;
    state_d        = RUN;
    if (hz.mem_busy) begin
      pc_write_s    = 1'b0;
      if_id_hold_s  = 1'b1;
      pipe_freeze_s = 1'b1;
      state_d       = MEM_WAIT;
    end else if (hz.ex_branch_taken && br_allow_s) begin
      if_id_flush_s  = 1'b1;
      id_ex_bubble_s = 1'b1;
      state_d        = FLUSH;
    end else if (lu_match_s && lu_allow_s) begin
      pc_write_s     = 1'b0;
      if_id_hold_s   = 1'b1;
      id_ex_bubble_s = 1'b1;
      state_d        = LU_STALL;
    end else begin
      state_d = RUN;
    end
    if (!reset) begin
      pc_write_s     = 1'b0;
      if_id_hold_s   = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_bubble_s = 1'b1;
      pipe_freeze_s  = 1'b0;
    end else begin
      pipe_freeze_s = pipe_freeze_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk         (clk),
    .reset       (reset),
    .mem_busy    (hz.mem_busy),
    .mem_timeout (mem_timeout_s)
  );

  assign hz.pc_write     = pc_write_s;
  assign hz.if_id_hold   = if_id_hold_s;
  assign hz.if_id_flush  = if_id_flush_s;
  assign hz.id_ex_bubble = id_ex_bubble_s;
  assign hz.pipe_freeze  = pipe_freeze_s;
  assign hz.mem_timeout  = mem_timeout_s;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [CNT_W-1:0] lu_cnt_d, lu_cnt_q;
  logic             flush_ev_s, lu_ev_s;

  // A branch flush is the only non-reset case with flush and PC advance together;
  // a load-use stall is the only case with hold and bubble together.
  assign flush_ev_s = if_id_flush_s && pc_write_s;
  assign lu_ev_s    = if_id_hold_s && id_ex_bubble_s;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (!pc_write_s && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_ev_s && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (lu_ev_s && !(&lu_cnt_q)) begin
      lu_cnt_d = lu_cnt_q + CNT_ONE;
    end else begin
      lu_cnt_d = lu_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_events = flush_cnt_q;
  assign hz.lu_events    = lu_cnt_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_events = '0;
  assign hz.lu_events    = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed cases with literal expectations, then
// random traffic checked each cycle against a behavioural model.
module tb_hazard_sequencer;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;
  localparam int MT    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic chk_on = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_sequencer_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz_if ();

  hazard_sequencer #(.REG_W(REG_W), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  // Model state: whether the previous cycle already spent a bubble on a
  // load-use or a branch, the busy run length, and the event tallies.
  bit          m_after_lu, m_after_flush, m_to;
  int          m_wd;
  int unsigned m_stall, m_flush, m_lu;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit lu_now();
    return hz_if.ex_mem_read && (hz_if.ex_rd != '0) &&
           ((hz_if.id_uses_rs1 && hz_if.id_rs1 == hz_if.ex_rd) ||
            (hz_if.id_uses_rs2 && hz_if.id_rs2 == hz_if.ex_rd));
  endfunction

  // Returns {pc_write, if_id_hold, if_id_flush, id_ex_bubble, pipe_freeze}.
  function automatic logic [4:0] exp_ctrl();
    if (!reset)                                         return 5'b00110;
    if (hz_if.mem_busy)                                 return 5'b01001;
    if (hz_if.ex_branch_taken && !m_after_flush)        return 5'b10110;
    if (lu_now() && !m_after_lu && !m_after_flush)      return 5'b01010;
    return 5'b10000;
  endfunction

  // Advance the model at each clock edge (or clear it on reset).
  always @(posedge clk or negedge reset) begin
    logic [4:0] e;
    if (!reset) begin
      m_after_lu = 0; m_after_flush = 0; m_to = 0; m_wd = 0;
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      e = exp_ctrl();
      if (hz_if.mem_busy) begin
        m_wd = (m_wd < MT) ? m_wd + 1 : MT;
        if (m_wd == MT) m_to = 1;
      end else begin
        m_wd = 0;
      end
      if (!e[4]) m_stall++;
      if (e[2]) m_flush++;
      if (e[3] && e[1]) m_lu++;
      m_after_flush = e[2];
      m_after_lu    = e[3] && e[1];
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic [4:0] e;
    if (chk_on) begin
      e = exp_ctrl();
      chk("pc_write",     32'(hz_if.pc_write),     32'(e[4]));
      chk("if_id_hold",   32'(hz_if.if_id_hold),   32'(e[3]));
      chk("if_id_flush",  32'(hz_if.if_id_flush),  32'(e[2]));
      chk("id_ex_bubble", 32'(hz_if.id_ex_bubble), 32'(e[1]));
      chk("pipe_freeze",  32'(hz_if.pipe_freeze),  32'(e[0]));
      chk("mem_timeout",  32'(hz_if.mem_timeout),  32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cycles", hz_if.stall_cycles, m_stall);
      chk("flush_events", hz_if.flush_events, m_flush);
      chk("lu_events",    hz_if.lu_events,    m_lu);
`else
      chk("stall_cycles", hz_if.stall_cycles, 32'd0);
      chk("flush_events", hz_if.flush_events, 32'd0);
      chk("lu_events",    hz_if.lu_events,    32'd0);
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    hz_if.id_rs1 = '0; hz_if.id_rs2 = '0;
    hz_if.id_uses_rs1 = 1'b0; hz_if.id_uses_rs2 = 1'b0;
    hz_if.ex_mem_read = 1'b0; hz_if.ex_rd = '0;
    hz_if.ex_branch_taken = 1'b0; hz_if.mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rd);
    hz_if.ex_mem_read = 1'b1; hz_if.ex_rd = rd;
    hz_if.id_rs2 = rd; hz_if.id_uses_rs2 = 1'b1;
  endtask

  // Literal check of the five control outputs: {pc, hold, flush, bubble, freeze}.
  task automatic lit(input string name, input logic [4:0] exp);
    chk(name, 32'({hz_if.pc_write, hz_if.if_id_hold, hz_if.if_id_flush,
                   hz_if.id_ex_bubble, hz_if.pipe_freeze}), 32'(exp));
  endtask

  initial begin
    int burst;
    burst = 0;
    quiet();
    chk_on = 1'b1;
    repeat (2) nxt();
    reset = 1'b1;
    #1 lit("post_reset_idle", 5'b10000);

    // Reset asserted in the middle of a memory stall.
    nxt(); hz_if.mem_busy = 1'b1;
    nxt(); nxt();
    nxt(); reset = 1'b0;
    #1 lit("reset_mid_stall", 5'b00110);
    nxt(); reset = 1'b1; quiet();
    #1 lit("reset_release", 5'b10000);
    chk("timeout_after_reset", 32'(hz_if.mem_timeout), 32'd0);

    // Single load-use stall, then release.
    nxt(); set_lu(5'd5);
    #1 lit("lu_stall", 5'b01010);
    nxt(); quiet();
    #1 lit("lu_release", 5'b10000);

    // Load to x0 is never a hazard.
    nxt(); set_lu(5'd0);
    #1 lit("lu_x0", 5'b10000);
    nxt(); quiet();

    // Static load-use for two cycles costs one bubble.
    nxt(); set_lu(5'd7);
    #1 lit("lu_hold_c1", 5'b01010);
    nxt();
    #1 lit("lu_hold_c2", 5'b10000);
    nxt(); quiet();

    // Branch beats load-use; repeated branch in FLUSH is ignored.
    nxt(); set_lu(5'd3); hz_if.ex_branch_taken = 1'b1;
    #1 lit("branch_flush", 5'b10110);
    nxt();
    #1 lit("branch_ignored", 5'b10000);
    nxt(); quiet();

    // Memory busy long enough to trip the watchdog.
    nxt(); hz_if.mem_busy = 1'b1;
    #1 lit("busy_c1", 5'b01001);
    nxt(); nxt(); nxt();
    #1 lit("busy_c4", 5'b01001);
    chk("timeout_before_4th", 32'(hz_if.mem_timeout), 32'd0);
    nxt(); hz_if.mem_busy = 1'b0;
    #1 chk("timeout_set", 32'(hz_if.mem_timeout), 32'd1);
    nxt();
    #1 chk("timeout_sticky", 32'(hz_if.mem_timeout), 32'd1);
    nxt(); reset = 1'b0;
    #1 chk("timeout_cleared", 32'(hz_if.mem_timeout), 32'd0);
    nxt(); reset = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
    // Two load-use stalls, one branch, three busy cycles.
    nxt(); set_lu(5'd9);
    nxt(); quiet();
    nxt(); set_lu(5'd4);
    nxt(); quiet();
    nxt(); hz_if.ex_branch_taken = 1'b1;
    nxt(); quiet();
    nxt(); hz_if.mem_busy = 1'b1;
    nxt(); nxt();
    nxt(); quiet();
    #1;
    chk("perf_lu",    hz_if.lu_events,    32'd2);
    chk("perf_flush", hz_if.flush_events, 32'd1);
    chk("perf_stall", hz_if.stall_cycles, 32'd5);
`endif

    // Random traffic with small register indices to make matches frequent.
    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      hz_if.id_rs1          = REG_W'($urandom_range(0, 3));
      hz_if.id_rs2          = REG_W'($urandom_range(0, 3));
      hz_if.ex_rd           = REG_W'($urandom_range(0, 3));
      hz_if.id_uses_rs1     = 1'($urandom_range(0, 1));
      hz_if.id_uses_rs2     = 1'($urandom_range(0, 1));
      hz_if.ex_mem_read     = 1'($urandom_range(0, 1));
      hz_if.ex_branch_taken = ($urandom_range(0, 6) == 0);
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 6);
      hz_if.mem_busy = (burst > 0);
      if (burst > 0) burst--;
    end
    nxt();
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Drives PC write enable, the IF/ID hold and flush controls, the ID/EX bubble and a global pipe freeze.
- Sources: load-use hazards, EX-stage taken branches/jumps, and data-memory wait.
- Small FSM suppresses redundant re-detection; a watchdog flags stuck memory.

Parameters:
- REG_W, 5, register index width.
- MEM_TIMEOUT, 64, consecutive mem_busy cycles before mem_timeout is raised (minimum 1).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  rs1 index of the instruction in ID.
- id_rs2  in  REG_W  rs2 index of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_W  destination of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect).
- mem_busy  in  1  data memory not ready in MEM stage.
- pc_write  out  1  PC register load enable.
- if_id_hold  out  1  IF/ID keeps current contents.
- if_id_flush  out  1  IF/ID loads zeros (NOP).
- id_ex_bubble  out  1  ID/EX loads zeros.
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold.
- mem_timeout  out  1  sticky watchdog error flag.
- stall_cycles  out  CNT_W  perf counter (optional feature).
- flush_events  out  CNT_W  perf counter (optional feature).
- lu_events  out  CNT_W  perf counter (optional feature).

Behaviour:
- FSM states: RUN, LU_STALL, FLUSH, MEM_WAIT. All are registered; reset state is RUN.
- Outputs are combinational from state and inputs, using the priority below. Default values: pc_write=1, all other control outputs 0.
- Reset asserted (reset=0), combinational override:
  - pc_write=0, if_id_flush=1, id_ex_bubble=1, if_id_hold=0, pipe_freeze=0.
  - State goes to RUN; watchdog count, mem_timeout and perf counters go to 0.
- Priority 1, mem_busy=1 (any state):
  - pc_write=0, if_id_hold=1, pipe_freeze=1; flush and bubble 0.
  - Next state MEM_WAIT.
  - Watchdog increments, saturating at MEM_TIMEOUT. On reaching MEM_TIMEOUT, mem_timeout sets and stays set until reset.
- Priority 2, ex_branch_taken=1 in RUN, LU_STALL or MEM_WAIT (with mem_busy=0):
  - pc_write=1, if_id_flush=1, id_ex_bubble=1.
  - Next state FLUSH.
  - In FLUSH, ex_branch_taken is ignored because EX holds a bubble.
- Priority 3, load-use in RUN or MEM_WAIT:
  - Condition: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_write=0, if_id_hold=1, id_ex_bubble=1. Next state LU_STALL.
- Load-use detection is suppressed in LU_STALL and FLUSH. Each hazard therefore costs at most 1 bubble.
- LU_STALL and FLUSH last exactly one cycle, then return to RUN unless a higher-priority event redirects.
- MEM_WAIT with mem_busy=0 behaves as RUN for that cycle, including hazard detection. The watchdog count clears.
- Watchdog count clears on any cycle with mem_busy=0.
- Register x0 never creates a hazard.
- if_id_hold and if_id_flush are never both 1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_write=0 outside reset.
  - flush_events increments on each branch flush.
  - lu_events increments on each load-use stall.
  - All counters saturate at all-ones and clear on reset.
- Undefined: counter ports are present but tied to 0, and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - state enum (RUN, LU_STALL, FLUSH, MEM_WAIT);
  - REG_W default and the x0 index constant;
  - CNT_W default.
- One sub-module, hazard_mem_watchdog, contains the saturating counter and sticky mem_timeout. Inputs: clk, reset, mem_busy.

Test Plan:
- Reset low mid-stall (mem_busy=1 for 3 cycles) -> immediately pc_write=0, if_id_flush=1, id_ex_bubble=1. After reset goes high with quiet inputs: state RUN, pc_write=1, all other outputs 0.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_write=0, if_id_hold=1, id_ex_bubble=1, then released. Repeat with ex_rd=0 -> no stall.
- Load-use inputs held static for 2 cycles -> exactly one stall cycle; the second cycle (LU_STALL) shows pc_write=1.
- ex_branch_taken=1 with simultaneous load-use match -> if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_hold=0. Next cycle branch input still 1 -> ignored.
- mem_busy=1 for MEM_TIMEOUT=4 cycles -> pipe_freeze=1 throughout and mem_timeout=1 after the 4th cycle. mem_timeout stays 1 after mem_busy drops, until reset.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls + 1 branch + 3 busy cycles -> lu_events=2, flush_events=1, stall_cycles=5.
